// File: rtl/trap_ctrl.sv
// Trap/return sequencer: owns the CSR write port, writes trap CSRs one per cycle
// on exception/interrupt/MRET, then redirects fetch and flushes the pipe.
module trap_ctrl #(
  parameter int DW     = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              exc_vld_i,
  input  logic [DW-1:0]     exc_cause_i,
  input  logic [DW-1:0]     exc_pc_i,
  input  logic [DW-1:0]     exc_tval_i,
  input  logic              mret_i,
  input  logic              irq_i,
  input  logic [DW-1:0]     int_pc_i,
  input  logic [DW-1:0]     csr_mtvec_i,
  input  logic [DW-1:0]     csr_mepc_i,
  input  logic [DW-1:0]     csr_mstatus_i,
  input  logic [CSR_AW-1:0] pipe_csr_waddr_i,
  input  logic              pipe_csr_wvld_i,
  input  logic [DW-1:0]     pipe_csr_wdata_i,
  output logic [CSR_AW-1:0] csr_waddr_o,
  output logic              csr_waddr_vld_o,
  output logic [DW-1:0]     csr_wdata_o,
  output logic              hold_o,
  output logic              flush_o,
  output logic              redirect_vld_o,
  output logic [DW-1:0]     redirect_pc_o,
  output logic [2:0]        state_dbg_o
);

  // Handshake: requests are single-cycle strobes sampled only in IDLE; there is
  // no ready back-channel -- hold_o stalls the pipe while the sequence runs.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_EPC   = 3'd1,
    W_CAUSE = 3'd2,
    W_TVAL  = 3'd3,
    W_STAT  = 3'd4,
    R_STAT  = 3'd5,
    JUMP    = 3'd6
  } state_t;

  localparam logic [CSR_AW-1:0] A_MSTATUS = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] A_MEPC    = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] A_MCAUSE  = CSR_AW'(12'h342);
  localparam logic [CSR_AW-1:0] A_MTVAL   = CSR_AW'(12'h343);
  localparam logic [DW-1:0]     IRQ_CAUSE = {1'b1, (DW-1)'(11)};

  state_t          state_q, state_d;
  logic [DW-1:0]   pc_q, cause_q, tval_q, snap_q;
  logic            is_irq_q, is_mret_q;
  logic            take_exc, take_mret, take_irq, load;
  logic [DW-1:0]   trap_stat, mret_stat, base, trap_target;

  assign take_exc  = exc_vld_i;
  assign take_mret = !exc_vld_i && mret_i;
  assign take_irq  = !exc_vld_i && !mret_i && irq_i && csr_mstatus_i[3];

  always_comb begin
    trap_stat        = snap_q;
    trap_stat[7]     = snap_q[3];
    trap_stat[3]     = 1'b0;
    trap_stat[12:11] = 2'b11;
    mret_stat        = snap_q;
    mret_stat[3]     = snap_q[7];
    mret_stat[7]     = 1'b1;
    mret_stat[12:11] = 2'b11;
  end

  // Vectored mode only offsets interrupts; exceptions always land on the base.
  assign base = {csr_mtvec_i[DW-1:2], 2'b00};
  assign trap_target = (is_irq_q && csr_mtvec_i[1:0] == 2'b01)
                       ? base + {{(DW-7){1'b0}}, cause_q[4:0], 2'b00}
                       : base;

  always_comb begin
    state_d         = state_q;
    load            = 1'b0;
    csr_waddr_o     = '0;
    csr_waddr_vld_o = 1'b0;
    csr_wdata_o     = '0;
    hold_o          = 1'b1;
    flush_o         = 1'b0;
    redirect_vld_o  = 1'b0;
    redirect_pc_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (take_exc || take_mret || take_irq) begin
          load    = 1'b1;
          state_d = take_mret ? R_STAT : W_EPC;
        end else begin
          hold_o          = 1'b0;
          csr_waddr_o     = pipe_csr_waddr_i;
          csr_waddr_vld_o = pipe_csr_wvld_i;
          csr_wdata_o     = pipe_csr_wdata_i;
        end
      end
      W_EPC: begin
        csr_waddr_o = A_MEPC; csr_wdata_o = pc_q; csr_waddr_vld_o = 1'b1;
        state_d = W_CAUSE;
      end
      W_CAUSE: begin
        csr_waddr_o = A_MCAUSE; csr_wdata_o = cause_q; csr_waddr_vld_o = 1'b1;
        state_d = W_TVAL;
      end
      W_TVAL: begin
        csr_waddr_o = A_MTVAL; csr_wdata_o = tval_q; csr_waddr_vld_o = 1'b1;
        state_d = W_STAT;
      end
      W_STAT: begin
        csr_waddr_o = A_MSTATUS; csr_wdata_o = trap_stat; csr_waddr_vld_o = 1'b1;
        state_d = JUMP;
      end
      R_STAT: begin
        csr_waddr_o = A_MSTATUS; csr_wdata_o = mret_stat; csr_waddr_vld_o = 1'b1;
        state_d = JUMP;
      end
      JUMP: begin
        flush_o        = 1'b1;
        redirect_vld_o = 1'b1;
        redirect_pc_o  = is_mret_q ? csr_mepc_i : trap_target;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset silences everything immediately so an aborted sequence emits nothing more.
    if (rst_i) begin
      load            = 1'b0;
      csr_waddr_o     = '0;
      csr_waddr_vld_o = 1'b0;
      csr_wdata_o     = '0;
      hold_o          = 1'b0;
      flush_o         = 1'b0;
      redirect_vld_o  = 1'b0;
      redirect_pc_o   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      cause_q   <= '0;
      tval_q    <= '0;
      snap_q    <= '0;
      is_irq_q  <= 1'b0;
      is_mret_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        pc_q      <= take_exc ? exc_pc_i : int_pc_i;
        cause_q   <= take_exc ? exc_cause_i : IRQ_CAUSE;
        tval_q    <= take_exc ? exc_tval_i : '0;
        snap_q    <= csr_mstatus_i;
        is_irq_q  <= take_irq;
        is_mret_q <= take_mret;
      end
    end
  end

  assign state_dbg_o = state_q;

endmodule
